// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and lane strobe helper for the data cache responder.
package dcache_pkg;
  typedef enum logic [1:0] {DM_BYTE = 2'b00, DM_HALF = 2'b01, DM_WORD = 2'b10} data_mode_e;
  typedef enum logic [1:0] {IDLE, FILL, WRITE, RESP} dc_state_e;
  function automatic logic [3:0] lane_strobe(input logic [1:0] mode, input logic [1:0] a);
    return mode == DM_BYTE ? 4'b0001 << a : mode == DM_HALF ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  endfunction
endpackage

// File: rtl/dcache_lane_align.sv
// dcache_lane_align: store replication/strobe, right-aligned load extraction and strobed byte merge.
module dcache_lane_align import dcache_pkg::*; (
  input  logic [1:0]  mode_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  input  logic [31:0] cword_i,
  output logic [31:0] wrep_o,
  output logic [3:0]  strb_o,
  output logic [31:0] lane_o,
  output logic [31:0] merged_o
);
  logic [31:0] mask, sh;
  always_comb begin
    strb_o = lane_strobe(mode_i, off_i);
    wrep_o = mode_i == DM_BYTE ? {4{wdata_i[7:0]}} : mode_i == DM_HALF ? {2{wdata_i[15:0]}} : wdata_i;
    mask = {{8{strb_o[3]}}, {8{strb_o[2]}}, {8{strb_o[1]}}, {8{strb_o[0]}}};
    merged_o = (cword_i & ~mask) | (wrep_o & mask);
    sh = rword_i >> {off_i, 3'b000};
    lane_o = mode_i == DM_BYTE ? {24'h0, sh[7:0]} :
             mode_i == DM_HALF ? {16'h0, off_i[1] ? rword_i[31:16] : rword_i[15:0]} : rword_i;
  end
endmodule

// File: rtl/dcache_responder.sv
// dcache_responder: direct-mapped write-through no-write-allocate data cache, 1-word lines, req/ack memory.
// Define MISALIGN_TRAP_EN to add the fault output that traps misaligned half/word accesses.
module dcache_responder import dcache_pkg::*; #(
  parameter int LINES  = 16,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              dcache_en,
  input  logic              dcache_rw,
  input  logic [1:0]        data_mode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
`ifdef MISALIGN_TRAP_EN
  ,
  output logic              fault
`endif
);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  dc_state_e state_q, state_d;
  logic [LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_q [LINES];
  logic [31:0] data_q [LINES];
  logic [31:0] rdata_q, rdata_d, line_d, wrep, lane, merged;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [3:0] strb;
  logic hit, mis, acc, line_we;
  assign idx = addr[IDX_W+1:2];
  assign tag = addr[ADDR_W-1:IDX_W+2];
  assign hit = valid_q[idx] && tag_q[idx] == tag;
`ifdef MISALIGN_TRAP_EN
  assign mis = data_mode == DM_HALF ? addr[0] : data_mode != DM_BYTE && addr[1:0] != 2'b00;
  assign fault = rstn && state_q == IDLE && dcache_en && mis;
`else
  assign mis = 1'b0;
`endif
  // RESP deliberately leaves acc low so the finished request is not looked up again
  assign acc = state_q == IDLE && dcache_en && !mis;
  dcache_lane_align u_align (
    .mode_i   (data_mode),
    .off_i    (addr[1:0]),
    .wdata_i  (wdata),
    .rword_i  (state_q == FILL ? mem_rdata : data_q[idx]),
    .cword_i  (data_q[idx]),
    .wrep_o   (wrep),
    .strb_o   (strb),
    .lane_o   (lane),
    .merged_o (merged)
  );
  always_comb begin
    state_d = state_q == IDLE ? (acc ? (dcache_rw ? WRITE : hit ? IDLE : FILL) : IDLE) :
              state_q == RESP ? IDLE : mem_ack ? RESP : state_q;
    valid_d = valid_q;
    rdata_d = rdata_q;
    line_we = 1'b0;
    line_d = mem_rdata;
    if (acc && !dcache_rw && hit) rdata_d = lane;
    if (state_q == FILL && mem_ack) begin
      valid_d[idx] = 1'b1;
      line_we = 1'b1;
      rdata_d = lane;
    end
    if (state_q == WRITE && mem_ack && hit) begin
      line_we = 1'b1;
      line_d = merged;
    end
  end
  assign busy = rstn && (state_q == FILL || state_q == WRITE || (acc && (dcache_rw || !hit)));
  assign rdata = acc && !dcache_rw && hit ? lane : rdata_q;
  assign mem_req = state_q == FILL || state_q == WRITE;
  assign mem_we = state_q == WRITE;
  assign mem_addr = {addr[ADDR_W-1:2], 2'b00};
  assign mem_wdata = wrep;
  assign mem_wstrb = mem_we ? strb : 4'b0000;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      valid_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
    end
  end
  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_q[idx] <= tag;
      data_q[idx] <= line_d;
    end
  end
endmodule

// File: tb/tb_dcache_responder.sv
// tb_dcache_responder: randomized scoreboard bench; memory-consistent load model plus hit/miss cache tracking.
module tb_dcache_responder;
  localparam int LINES = 16;
  typedef struct {bit ld; logic [31:0] rd; int bc; bit flt;} exp_t;
  typedef struct {bit we; logic [31:0] a; logic [31:0] d; logic [3:0] s;} mt_t;
  logic clk = 0, rstn = 0, dcache_en = 0, dcache_rw = 0, mem_ack = 0;
  logic [1:0] data_mode = 0;
  logic [31:0] addr = 0, wdata = 0, mem_rdata = 0;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [3:0] mem_wstrb;
  logic busy, mem_req, mem_we;
`ifdef MISALIGN_TRAP_EN
  logic fault;
`endif
  int total = 0, bad = 0, ack_dly = 0, mon_bc = 0;
  logic [31:0] last_rd = 0, mon_rd = 0;
  exp_t sq[$];
  mt_t mq[$];
  logic [31:0] mem [int unsigned];
  bit rv [LINES];
  logic [25:0] rt [LINES];
  always #5 clk = ~clk;
  dcache_responder #(.LINES(LINES), .ADDR_W(32)) dut (
    .clk(clk), .rstn(rstn), .dcache_en(dcache_en), .dcache_rw(dcache_rw), .data_mode(data_mode),
    .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
`ifdef MISALIGN_TRAP_EN
    , .fault(fault)
`endif
  );
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask
  function automatic logic [31:0] rdmem(input logic [31:0] wa);
    return mem.exists(wa) ? mem[wa] : (wa * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction
  function automatic logic [3:0] strb_of(input logic [1:0] m, input logic [1:0] a);
    return m == 2'd0 ? 4'b0001 << a : m == 2'd1 ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  endfunction
  function automatic logic [31:0] rep_of(input logic [1:0] m, input logic [31:0] d);
    return m == 2'd0 ? {4{d[7:0]}} : m == 2'd1 ? {2{d[15:0]}} : d;
  endfunction
  function automatic logic [31:0] lane_of(input logic [31:0] w, input logic [1:0] m, input logic [1:0] a);
    return m == 2'd0 ? (w >> (8 * a)) & 32'hFF : m == 2'd1 ? (w >> (16 * a[1])) & 32'hFFFF : w;
  endfunction
  // scoreboard monitor: one completion per request, where the DUT shows the request with busy low
  initial begin
    int bc;
    exp_t e;
    bc = 0;
    forever begin
      @(negedge clk);
      if (!rstn) bc = 0;
      else if (!dcache_en) chk("idle_busy", {31'h0, busy}, 32'h0);
      else if (busy) bc++;
      else begin
        if (sq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_completion addr %h", addr);
        end else begin
          e = sq.pop_front();
          chk("rdata", rdata, e.rd);
          chk("busy_cycles", 32'(bc), 32'(e.bc));
`ifdef MISALIGN_TRAP_EN
          chk("fault", {31'h0, fault}, {31'h0, e.flt});
`endif
        end
        mon_rd = rdata;
        mon_bc = bc;
        bc = 0;
      end
    end
  end
  // backing memory: checks each requested transfer against the expected one, acks after ack_dly cycles
  initial begin
    int cnt;
    mt_t m;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (rstn && mem_req) begin
        if (mq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL mem_unexpected addr %h", mem_addr);
          mem_ack = 1;
        end else begin
          m = mq[0];
          chk("mem_we", {31'h0, mem_we}, {31'h0, m.we});
          chk("mem_addr", mem_addr, m.a);
          if (m.we) begin
            chk("mem_wdata", mem_wdata, m.d);
            chk("mem_wstrb", {28'h0, mem_wstrb}, {28'h0, m.s});
          end
          if (cnt >= ack_dly) begin
            mem_ack = 1;
            mem_rdata = rdmem(mem_addr >> 2);
            mq.delete(0);
            cnt = 0;
          end else begin
            mem_ack = 0;
            cnt++;
          end
        end
      end else begin
        cnt = 0;
        mem_ack = $urandom_range(0, 7) == 0;
        mem_rdata = $urandom;
      end
    end
  end
  task automatic do_req(input bit rw, input logic [1:0] m, input logic [31:0] a, input logic [31:0] wd, input int dly);
    exp_t e;
    logic [31:0] w, rp, wa;
    logic [3:0] s;
    logic [25:0] t;
    int i;
    bit mis, ok;
    wa = a >> 2;
    i = int'(a[5:2]);
    t = a[31:6];
    s = strb_of(m, a[1:0]);
    rp = rep_of(m, wd);
`ifdef MISALIGN_TRAP_EN
    mis = m == 2'd1 ? a[0] : (m != 2'd0 && a[1:0] != 2'b00);
`else
    mis = 0;
`endif
    e.ld = !rw;
    e.flt = mis;
    e.rd = last_rd;
    e.bc = 0;
    if (!mis && rw) begin
      mq.push_back('{1'b1, {a[31:2], 2'b00}, rp, s});
      w = rdmem(wa);
      for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = rp[8*b +: 8];
      mem[wa] = w;
      e.bc = 2 + dly;
    end else if (!mis) begin
      if (!(rv[i] && rt[i] == t)) begin
        mq.push_back('{1'b0, {a[31:2], 2'b00}, 32'h0, 4'h0});
        e.bc = 2 + dly;
        rv[i] = 1;
        rt[i] = t;
      end
      e.rd = lane_of(rdmem(wa), m, a[1:0]);
      last_rd = e.rd;
    end
    sq.push_back(e);
    ack_dly = dly;
    dcache_en = 1;
    dcache_rw = rw;
    data_mode = m;
    addr = a;
    wdata = wd;
    ok = 0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      ok = !busy;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL timeout waiting for completion addr %h", a);
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    dcache_en = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst_mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
`ifdef MISALIGN_TRAP_EN
    chk("rst_fault", {31'h0, fault}, 32'h0);
`endif
    dcache_en = 0;
    rstn = 1;
    @(posedge clk);
    #1;
    mem[32'h40] = 32'hDEADBEEF;
    do_req(0, 2'd2, 32'h100, 0, 2);
    chk("cold_rdata", mon_rd, 32'hDEADBEEF);
    chk("cold_busy", 32'(mon_bc), 32'd4);
    do_req(0, 2'd2, 32'h100, 0, 0);
    chk("hit_rdata", mon_rd, 32'hDEADBEEF);
    chk("hit_busy", 32'(mon_bc), 32'd0);
    do_req(0, 2'd0, 32'h103, 0, 1);
    chk("byte_rdata", mon_rd, 32'h000000DE);
    do_req(1, 2'd0, 32'h101, 32'hAB, 1);
    do_req(0, 2'd2, 32'h100, 0, 1);
    chk("merge_rdata", mon_rd, 32'hDEADABEF);
    do_req(0, 2'd2, 32'h100 + 4 * LINES, 0, 1);
    chk("conflict_busy", 32'(mon_bc), 32'd3);
    do_req(0, 2'd2, 32'h100, 0, 0);
    chk("evicted_busy", 32'(mon_bc), 32'd2);
    do_req(0, 2'd1, 32'h101, 0, 1);
`ifdef MISALIGN_TRAP_EN
    chk("misalign_rdata", mon_rd, 32'hDEADABEF);
`else
    chk("half_low_rdata", mon_rd, 32'h0000ABEF);
`endif
    dcache_en = 1;
    dcache_rw = 1;
    data_mode = 2'd2;
    addr = 32'h100;
    wdata = 32'h12345678;
    ack_dly = 1000;
    mq.push_back('{1'b1, 32'h100, 32'h12345678, 4'hF});
    repeat (3) @(posedge clk);
    #1;
    chk("write_req", {31'h0, mem_req}, 32'h1);
    rstn = 0;
    #1;
    chk("rst_drop_req", {31'h0, mem_req}, 32'h0);
    chk("rst_drop_busy", {31'h0, busy}, 32'h0);
    dcache_en = 0;
    mq.delete();
    sq.delete();
    foreach (rv[i]) rv[i] = 0;
    last_rd = 0;
    @(posedge clk);
    #1;
    rstn = 1;
    ack_dly = 0;
    @(posedge clk);
    #1;
    do_req(0, 2'd2, 32'h100, 0, 1);
    chk("post_rst_busy", 32'(mon_bc), 32'd3);
    chk("post_rst_rdata", mon_rd, 32'hDEADABEF);
    repeat (400) begin
      if ($urandom_range(0, 3) == 0) begin
        dcache_en = 0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      do_req($urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)), $urandom_range(0, 255), $urandom,
             $urandom_range(0, 3));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
